uart_tx_arbiter: RTL

//  Shares one UART transmit line among NUM_REQ requesters: round-robin grant, one frame per grant.

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and frame constants for the arbitrated UART transmitter.
package uart_tx_arbiter_pkg;

    // Transmit FSM states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // Line levels for the framing bits; the idle level equals the stop level.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: starting one past ptr_i, the first asserted
// request wins. Kept free of UART specifics so other arbiters can reuse it.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int          cand;
    logic [IW-1:0] cand_idx;

    // Scan ptr+1, ptr+2, ... wrapping at N; the first hit is the winner.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(ptr_i) + k) % N;
            cand_idx = IW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter: accepts one byte per grant from
// NUM_REQ clients and sends it as 8N1/8N2, one bit per external baud_tick.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    localparam int IW       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [IW-1:0]             grant_id,
    output logic                      busy,
    output logic                      tx
);

    localparam int            BW        = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    state_e              state_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       grant_id_q;
    logic                busy_q;
    logic                tx_q;
    logic [BW-1:0]       bit_cnt_q;
    logic                stop_cnt_q;
    logic [DATA_W-1:0]   shift_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic                accept;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Ready is only offered in IDLE and never while reset is held.
    assign accept    = rst_n && (state_q == ST_IDLE) && arb_any;
    assign req_ready = accept ? arb_gnt : '0;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign tx        = tx_q;

    // Pick the byte slice belonging to the current winner.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Shift register: loaded on accept, advanced as each data bit is put on the line.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= sel_data;
        end else if (baud_tick &&
                     ((state_q == ST_START) ||
                      ((state_q == ST_DATA) && (bit_cnt_q != BIT_LAST)))) begin
            shift_q <= shift_q >> 1;
        end
    end

    // Frame FSM with registered line, busy flag, grant index and RR pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IW'(NUM_REQ - 1);
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            tx_q       <= STOP_LVL;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A tick here is ignored; the start bit waits for the next one.
                    if (accept) begin
                        grant_id_q <= arb_idx;
                        ptr_q      <= arb_idx;
                        busy_q     <= 1'b1;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (baud_tick) begin
                        tx_q    <= START_BIT;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            tx_q       <= STOP_LVL;
                            stop_cnt_q <= 1'b0;
                            state_q    <= ST_STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    tx_q    <= STOP_LVL;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
